// File: rtl/tb_status_periph_pkg.sv
// rtl/tb_status_periph_pkg.sv - shared constants, address select enum and decode helper
package tb_status_periph_pkg;

  localparam logic [31:0] DEFAULT_PRINT_ADDR  = 32'h1000_0000;
  localparam logic [31:0] DEFAULT_STATUS_ADDR = 32'h2000_0000;
  localparam logic [31:0] DEFAULT_EXIT_ADDR   = 32'h2000_0004;
  localparam logic [31:0] DEFAULT_CYCLE_ADDR  = 32'h1500_1000;

  localparam logic [31:0] TEST_PASS_MAGIC = 32'd123456789;
  localparam logic [31:0] TEST_FAIL_MAGIC = 32'd1;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_PRINT,
    SEL_STATUS,
    SEL_EXIT,
    SEL_CYCLE
  } addr_sel_e;

  // Word-address compare; byte lanes within a word all select the same register.
  function automatic addr_sel_e decode_addr(
    input logic [29:0] word,
    input logic [29:0] print_w,
    input logic [29:0] status_w,
    input logic [29:0] exit_w,
    input logic [29:0] cycle_w
  );
    if (word == print_w) return SEL_PRINT;
    else if (word == status_w) return SEL_STATUS;
    else if (word == exit_w) return SEL_EXIT;
    else if (word == cycle_w) return SEL_CYCLE;
    else return SEL_NONE;
  endfunction

endpackage

// File: rtl/tb_status_periph_if.sv
// rtl/tb_status_periph_if.sv - OBI-style data bus between core and virtual peripherals
interface tb_status_periph_if;

  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );

endinterface

// File: rtl/tb_status_periph_print_fifo.sv
// rtl/tb_status_periph_print_fifo.sv - synchronous character FIFO, push/full in, valid/ready out
module tb_print_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  output logic       full_o,
  output logic       valid_o,
  output logic [7:0] data_o,
  input  logic       ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic        empty;
  logic        pop;
  logic        push_ok;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (pointers equal).
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign valid_o = ~empty & ~rst_i;
  assign data_o  = valid_o ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
  assign pop     = valid_o & ready_i;
  assign push_ok = push_i & ~full_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = data_i;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/tb_status_periph.sv
// rtl/tb_status_periph.sv - bus responder for stdout, test status, exit and cycle counter
module tb_status_periph
  import tb_status_periph_pkg::*;
#(
  parameter logic [31:0] PRINT_ADDR       = DEFAULT_PRINT_ADDR,
  parameter logic [31:0] STATUS_ADDR      = DEFAULT_STATUS_ADDR,
  parameter logic [31:0] EXIT_ADDR        = DEFAULT_EXIT_ADDR,
  parameter logic [31:0] CYCLE_ADDR       = DEFAULT_CYCLE_ADDR,
  parameter int          PRINT_FIFO_DEPTH = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  tb_status_periph_if.slave   bus,
  output logic                char_valid_o,
  output logic [7:0]          char_o,
  input  logic                char_ready_i,
  output logic                tests_passed_o,
  output logic                tests_failed_o,
  output logic                exit_valid_o,
  output logic [31:0]         exit_value_o
);

  addr_sel_e   sel;
  logic        fifo_full;
  logic        gnt;
  logic        wr;
  logic        full_be;
  logic        push;
  logic        unused_addr_lsb;

  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cnt_q, cnt_d;
  logic        passed_q, passed_d;
  logic        failed_q, failed_d;
  logic        exit_valid_q, exit_valid_d;
  logic [31:0] exit_value_q, exit_value_d;

  assign unused_addr_lsb = ^bus.addr_i[1:0];

  always_comb begin
    sel = decode_addr(bus.addr_i[31:2], PRINT_ADDR[31:2], STATUS_ADDR[31:2],
                      EXIT_ADDR[31:2], CYCLE_ADDR[31:2]);
  end

  always_comb begin
    // Only a byte-0 stdout write can stall, and only on the registered full flag.
    gnt     = bus.req_i & ~rst_i &
              ~(bus.we_i & (sel == SEL_PRINT) & bus.be_i[0] & fifo_full);
    wr      = gnt & bus.we_i;
    full_be = (bus.be_i == 4'hF);
    push    = wr & (sel == SEL_PRINT) & bus.be_i[0];

    rvalid_d = gnt;
    rdata_d  = (gnt & ~bus.we_i & (sel == SEL_CYCLE)) ? cnt_q : 32'h0;

    cnt_d = cnt_q + 32'd1;
    if (wr && (sel == SEL_CYCLE) && full_be) begin
      cnt_d = bus.wdata_i;
    end

    passed_d = passed_q |
               (wr & (sel == SEL_STATUS) & full_be & (bus.wdata_i == TEST_PASS_MAGIC));
    failed_d = failed_q |
               (wr & (sel == SEL_STATUS) & full_be & (bus.wdata_i == TEST_FAIL_MAGIC));

    exit_valid_d = exit_valid_q;
    exit_value_d = exit_value_q;
    if (wr && (sel == SEL_EXIT) && full_be && !exit_valid_q) begin
      exit_valid_d = 1'b1;
      exit_value_d = bus.wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'h0;
      cnt_q        <= 32'h0;
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_value_q <= 32'h0;
    end else begin
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
      passed_q     <= passed_d;
      failed_q     <= failed_d;
      exit_valid_q <= exit_valid_d;
      exit_value_q <= exit_value_d;
    end
  end

  tb_print_fifo #(
    .DEPTH (PRINT_FIFO_DEPTH)
  ) u_print_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (bus.wdata_i[7:0]),
    .full_o  (fifo_full),
    .valid_o (char_valid_o),
    .data_o  (char_o),
    .ready_i (char_ready_i)
  );

  // Registered outputs are masked so they read zero during the very first reset cycle too.
  assign bus.gnt_o      = gnt;
  assign bus.rvalid_o   = rvalid_q & ~rst_i;
  assign bus.rdata_o    = rst_i ? 32'h0 : rdata_q;
  assign tests_passed_o = passed_q & ~rst_i;
  assign tests_failed_o = failed_q & ~rst_i;
  assign exit_valid_o   = exit_valid_q & ~rst_i;
  assign exit_value_o   = rst_i ? 32'h0 : exit_value_q;

endmodule
